// File: rtl/emu_host_pkg.sv
// Shared types and constants for the host wire-in bridge: FSM states, host word layout, default FIFO depth.
package emu_host_pkg;

    localparam int HOST_WORD_W   = 32;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_LOW = 2'd2
    } host_state_t;

    typedef struct packed {
        logic [HOST_WORD_W-1:0] hi;
        logic [HOST_WORD_W-1:0] lo;
    } host_word_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/wire_in_enq_bridge_if.sv
// Host wire-in/wire-out signals plus the decoupled dequeue port toward the emulator core.
interface wire_in_enq_bridge_if #(
    parameter int WORD_W = 64
);
    import emu_host_pkg::*;

    logic                   host_valid;
    logic [HOST_WORD_W-1:0] host_bits_0;
    logic [HOST_WORD_W-1:0] host_bits_1;
    logic                   host_ready;
    logic                   host_ovf;
    logic                   host_ovf_clr;
    logic                   deq_valid;
    logic                   deq_ready;
    logic [WORD_W-1:0]      deq_bits;

    modport master (
        output host_valid, host_bits_0, host_bits_1, host_ovf_clr, deq_ready,
        input  host_ready, host_ovf, deq_valid, deq_bits
    );

    modport slave (
        input  host_valid, host_bits_0, host_bits_1, host_ovf_clr, deq_ready,
        output host_ready, host_ovf, deq_valid, deq_bits
    );

endinterface

// File: rtl/host_sync_fifo.sv
// Synchronous FIFO: wrapping pointers plus a separate count to tell full from empty.
// Latency: a push is visible on head the next cycle; no bypass. Backpressure: push ignored when full, pop ignored when empty.
module host_sync_fifo #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic              full_next
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic              push_ok;
    logic              pop_ok;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign count_next = count + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};
    assign full_next = (count_next == FULL_CNT);
    assign head      = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wire_in_enq_bridge.sv
// Turns a host wire-in valid level into single FIFO pushes; optional stats via WIRE_IN_ENQ_BRIDGE_STATS_EN.
// Latency: word on deq_bits 2 cycles after host_valid first sampled high. Backpressure: host_ready low when full; edges while full are dropped and flagged sticky in host_ovf.
module wire_in_enq_bridge
    import emu_host_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int WORD_W = 2 * HOST_WORD_W
) (
    input  logic                 clock,
    input  logic                 reset,
    wire_in_enq_bridge_if.slave  bus
`ifdef WIRE_IN_ENQ_BRIDGE_STATS_EN
    ,
    output logic [31:0]          stat_enq_cnt,
    output logic [31:0]          stat_drop_cnt
`endif
);
    host_state_t state_q;
    host_state_t state_d;
    logic        capture;
    logic        push_ok;
    logic        ovf_set;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_full_next;
    logic        ovf_q;
    logic        ready_q;
    host_word_t  cap_word;

    assign cap_word = '{hi: bus.host_bits_1, lo: bus.host_bits_0};

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // CAPTURE never looks at host_valid; a drop of valid during it is seen in WAIT_LOW.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE:     if (bus.host_valid) state_d = CAPTURE;
            CAPTURE: begin
                capture = 1'b1;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: if (!bus.host_valid) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Full is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
    assign push_ok = capture && !fifo_full;
    assign ovf_set = capture && fifo_full;

    host_sync_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_ok),
        .push_data (cap_word),
        .pop       (bus.deq_ready),
        .head      (bus.deq_bits),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .full_next (fifo_full_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            ovf_q   <= ovf_set | (ovf_q & ~bus.host_ovf_clr);
            ready_q <= !fifo_full_next;
        end
    end

    assign bus.host_ovf   = ovf_q;
    assign bus.host_ready = ready_q;
    assign bus.deq_valid  = !fifo_empty;

`ifdef WIRE_IN_ENQ_BRIDGE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_enq_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (push_ok) stat_enq_cnt  <= sat_inc(stat_enq_cnt);
            if (ovf_set) stat_drop_cnt <= sat_inc(stat_drop_cnt);
        end
    end
`endif

endmodule
